// File: rtl/i2c_reg_slave_pkg.sv
// Shared types and constants for the I2C register slave.
package i2c_reg_slave_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_IGNORE
  } state_e;

  localparam logic [6:0] DEV_ADDR_DEF = 7'b1000101;

  // Bus level of an acknowledge bit; the released (pulled-up) line reads as NACK.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for SCL/SDA plus one delayed copy for SCL edge and
// START/STOP condition detection.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_dly_q,  sda_dly_q;
  logic       scl_s,      sda_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_dly_q  <= scl_sync_q[1];
      sda_dly_q  <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign sda_o      = sda_s;
  assign scl_rise_o =  scl_s & ~scl_dly_q;
  assign scl_fall_o = ~scl_s &  scl_dly_q;
  // SDA may only move while SCL is stably high for a bus condition.
  assign start_o    = scl_s & scl_dly_q &  sda_dly_q & ~sda_s;
  assign stop_o     = scl_s & scl_dly_q & ~sda_dly_q &  sda_s;

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C register slave: 16 x 8-bit registers behind a wrapping pointer.
// Write: addr/W, pointer, data...; read: addr/R, data... (pointer advances on master ACK).
module i2c_reg_slave
  import i2c_reg_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int         NREG     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] io_out,
  output logic       wr_strobe,
  output logic [3:0] wr_index,
  output logic       busy
);

  logic       sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [6:0] tx_q, tx_d;
  logic [3:0] ptr_q, ptr_d, ptr_inc;
  logic       sda_out_q, sda_out_d;
  logic       wr_en, wr_strobe_q;
  logic [3:0] wr_index_q;
  logic [7:0] regs_q [NREG];

  i2c_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (i2c_scl),
    .sda_i     (i2c_sda),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  assign ptr_inc = ptr_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    sda_out_d = sda_out_q;
    wr_en     = 1'b0;
    if (start_det) begin
      state_d   = S_ADDR;
      cnt_d     = '0;
      sda_out_d = NACK;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      sda_out_d = NACK;
    end else if (scl_rise) begin
      case (state_q)
        S_ADDR, S_PTR, S_WDATA, S_RDATA_ACK: begin
          sr_d  = {sr_q[6:0], sda_s};
          cnt_d = cnt_q + 4'd1;
        end
        S_RDATA: cnt_d = cnt_q + 4'd1;
        default: ;
      endcase
    end else if (scl_fall) begin
      // All drive changes happen here, while SCL is low.
      case (state_q)
        S_ADDR: if (cnt_q == 4'd8) begin
          if (sr_q[7:1] == DEV_ADDR) begin
            state_d   = S_ADDR_ACK;
            sda_out_d = ACK;
          end else begin
            state_d   = S_IGNORE;
          end
        end
        S_ADDR_ACK: begin
          cnt_d = '0;
          if (sr_q[0]) begin
            state_d   = S_RDATA;
            tx_d      = regs_q[ptr_q][6:0];
            sda_out_d = regs_q[ptr_q][7];
          end else begin
            state_d   = S_PTR;
            sda_out_d = NACK;
          end
        end
        S_PTR: if (cnt_q == 4'd8) begin
          ptr_d     = sr_q[3:0];
          state_d   = S_PTR_ACK;
          sda_out_d = ACK;
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          state_d   = S_WDATA;
          cnt_d     = '0;
          sda_out_d = NACK;
        end
        S_WDATA: if (cnt_q == 4'd8) begin
          wr_en     = 1'b1;
          ptr_d     = ptr_inc;
          state_d   = S_WDATA_ACK;
          sda_out_d = ACK;
        end
        S_RDATA: if (cnt_q == 4'd8) begin
          state_d   = S_RDATA_ACK;
          cnt_d     = '0;
          sda_out_d = NACK;
        end else begin
          tx_d      = {tx_q[5:0], 1'b0};
          sda_out_d = tx_q[6];
        end
        S_RDATA_ACK: begin
          cnt_d = '0;
          if (sr_q[0] == NACK) begin
            state_d   = S_IGNORE;
            sda_out_d = NACK;
          end else begin
            ptr_d     = ptr_inc;
            state_d   = S_RDATA;
            tx_d      = regs_q[ptr_inc][6:0];
            sda_out_d = regs_q[ptr_inc][7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      sda_out_q   <= NACK;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      sda_out_q   <= sda_out_d;
      wr_strobe_q <= wr_en;
      if (wr_en) begin
        regs_q[ptr_q] <= sr_q;
        wr_index_q    <= ptr_q;
      end
    end
  end

  assign i2c_sda   = sda_out_q ? 1'bz : 1'b0;
  assign io_out    = regs_q[0];
  assign wr_strobe = wr_strobe_q;
  assign wr_index  = wr_index_q;
  assign busy      = !(state_q inside {S_IDLE, S_ADDR, S_IGNORE});

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged I2C master with a register-map model.
module tb_i2c_reg_slave;

  localparam int         Q    = 5;
  localparam logic [6:0] ADDR = 7'h45;

  logic       clk = 1'b0, rst = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire        sda;
  logic [7:0] io_out;
  logic       wr_strobe, busy;
  logic [3:0] wr_index;

  int         tests = 0, fails = 0;
  int         strobe_cnt = 0;
  logic [3:0] strobe_idx[$];
  logic [7:0] mreg [16];
  logic [3:0] mptr;
  logic [7:0] wbuf[$];
  logic       ack;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_reg_slave #(.DEV_ADDR(ADDR), .NREG(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .i2c_scl  (scl),
    .i2c_sda  (sda),
    .io_out   (io_out),
    .wr_strobe(wr_strobe),
    .wr_index (wr_index),
    .busy     (busy)
  );

  always @(negedge clk) if (wr_strobe) begin
    strobe_cnt++;
    strobe_idx.push_back(wr_index);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mreset();
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    mptr = 4'd0;
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b1; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b0; wait_clk(Q);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b; wait_clk(Q);
    scl = 1'b1; wait_clk(2*Q);
    scl = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_low = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    a = sda;      wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q); scl = 1'b1;
      wait_clk(Q); b[i] = sda;
      wait_clk(Q); scl = 1'b0;
    end
    wait_clk(Q); m_low = ~nack;
    wait_clk(Q); scl = 1'b1;
    wait_clk(2*Q); scl = 1'b0;
    wait_clk(Q); m_low = 1'b0;
  endtask

  // Pointer byte carries random upper bits, which the slave must ignore.
  task automatic write_burst(input logic [3:0] p, input string tag);
    logic a;
    logic [3:0] e;
    int n;
    n = wbuf.size();
    strobe_cnt = 0; strobe_idx.delete();
    i2c_start();
    send_byte({ADDR, 1'b0}, a);          chk({tag, "_aack"}, a, 0);
    chk({tag, "_busy1"}, busy, 1);
    send_byte({4'($urandom), p}, a);     chk({tag, "_pack"}, a, 0);
    mptr = p;
    foreach (wbuf[i]) begin
      send_byte(wbuf[i], a);             chk({tag, "_dack"}, a, 0);
      mreg[mptr] = wbuf[i];
      mptr = mptr + 4'd1;
    end
    i2c_stop(); wait_clk(4);
    chk({tag, "_nstb"}, strobe_cnt, n);
    for (int i = 0; i < n; i++) begin
      e = p + 4'(i);
      if (i < strobe_idx.size()) chk({tag, "_widx"}, strobe_idx[i], e);
    end
    chk({tag, "_io"}, io_out, mreg[0]);
    chk({tag, "_busy0"}, busy, 0);
  endtask

  task automatic read_burst(input int n, input logic set_ptr, input logic [3:0] p, input string tag);
    logic a;
    logic [7:0] b;
    i2c_start();
    if (set_ptr) begin
      send_byte({ADDR, 1'b0}, a);        chk({tag, "_wack"}, a, 0);
      send_byte({4'($urandom), p}, a);   chk({tag, "_pack"}, a, 0);
      mptr = p;
      i2c_start();
    end
    send_byte({ADDR, 1'b1}, a);          chk({tag, "_aack"}, a, 0);
    for (int i = 0; i < n; i++) begin
      read_byte(b, i == n - 1);
      chk({tag, "_data"}, b, mreg[mptr]);
      if (i != n - 1) mptr = mptr + 4'd1;
    end
    chk({tag, "_rel"}, sda, 1);
    i2c_stop(); wait_clk(4);
    chk({tag, "_busy0"}, busy, 0);
  endtask

  initial begin
    mreset();
    wait_clk(5);
    chk("rst_io", io_out, 0);
    chk("rst_stb", wr_strobe, 0);
    chk("rst_idx", wr_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda, 1);
    rst = 1'b1;
    wait_clk(5);

    // Basic single write.
    wbuf = {8'hAA};
    write_burst(4'h0, "w_basic");
    chk("w_basic_io", io_out, 8'hAA);

    // Pointer wrap from 15 to 0.
    wbuf = {8'h11, 8'h22};
    write_burst(4'hF, "w_wrap");
    chk("w_wrap_io", io_out, 8'h22);
    read_burst(2, 1'b1, 4'hF, "r_wrap");

    // Foreign address: no ACK, never busy, no writes.
    strobe_cnt = 0;
    i2c_start();
    send_byte({7'h44, 1'b0}, ack); chk("bad_aack", ack, 1);
    chk("bad_busy", busy, 0);
    send_byte(8'h00, ack);         chk("bad_pack", ack, 1);
    send_byte(8'h5A, ack);         chk("bad_dack", ack, 1);
    i2c_stop(); wait_clk(4);
    chk("bad_nstb", strobe_cnt, 0);
    chk("bad_io", io_out, mreg[0]);

    // Fill the whole map with random data.
    wbuf.delete();
    for (int i = 0; i < 16; i++) wbuf.push_back(8'($urandom));
    write_burst(4'h0, "fill");

    // Pointer write, repeated START read: ACK then NACK.
    wbuf = {8'($urandom), 8'($urandom)};
    write_burst(4'h3, "w_r3");
    read_burst(2, 1'b1, 4'h3, "rs_read");

    // STOP after a partial data byte.
    strobe_cnt = 0;
    i2c_start();
    send_byte({ADDR, 1'b0}, ack); chk("part_aack", ack, 0);
    send_byte(8'h07, ack);        chk("part_pack", ack, 0);
    mptr = 4'h7;
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    i2c_stop(); wait_clk(4);
    chk("part_nstb", strobe_cnt, 0);
    chk("part_busy", busy, 0);
    read_burst(1, 1'b0, 4'h0, "part_rd");

    // Randomised mix of write and read transactions.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        wbuf.delete();
        repeat ($urandom_range(1, 4)) wbuf.push_back(8'($urandom));
        write_burst(4'($urandom), "rnd_w");
      end else begin
        read_burst(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), 4'($urandom), "rnd_r");
      end
    end

    // Reset in the middle of a read byte while the slave drives SDA low.
    wbuf = {8'h01};
    write_burst(4'h9, "rst_prep");
    i2c_start();
    send_byte({ADDR, 1'b0}, ack); chk("mid_wack", ack, 0);
    send_byte(8'h09, ack);        chk("mid_pack", ack, 0);
    i2c_start();
    send_byte({ADDR, 1'b1}, ack); chk("mid_aack", ack, 0);
    for (int i = 0; i < 3; i++) begin
      wait_clk(Q); scl = 1'b1;
      wait_clk(2*Q); scl = 1'b0;
    end
    wait_clk(Q);
    chk("mid_drv", sda, 0);
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_sda", sda, 1);
    chk("mid_io", io_out, 0);
    chk("mid_stb", wr_strobe, 0);
    chk("mid_idx", wr_index, 0);
    chk("mid_busy0", busy, 0);
    wait_clk(3);
    rst = 1'b1;
    mreset();
    scl = 1'b1;
    wait_clk(4*Q);
    chk("post_busy", busy, 0);
    wbuf = {8'h5A};
    write_burst(4'h2, "post_w");
    read_burst(1, 1'b1, 4'h2, "post_r2");
    read_burst(1, 1'b1, 4'h9, "post_r9");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
